// File: rtl/bus_register.sv
// General-purpose WIDTH-bit register on the shared tri-state system bus.
// Optional synchronous clear is compiled in with `define REGISTER_CLEAR_EN.
module bus_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             enable,
  input  logic             load,
`ifdef REGISTER_CLEAR_EN
  input  logic             clear,
`endif
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // A load while this unit drives the bus would capture its own output,
  // so drive wins and the register holds.
  always_comb begin
    q_d = q_q;
`ifdef REGISTER_CLEAR_EN
    if (clear) begin
      q_d = '0;
    end else if (load && !enable) begin
      q_d = bus;
    end
`else
    if (load && !enable) begin
      q_d = bus;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus   = enable ? q_q : {WIDTH{1'bz}};
  assign value = q_q;

endmodule

// File: tb/tb_bus_register.sv
// Directed bench for bus_register: expected values are queued when stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_bus_register;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       load;
  logic       drv_en;
  logic [7:0] drv;
  wire  [7:0] bus;
  logic [7:0] value;
`ifdef REGISTER_CLEAR_EN
  logic       clear;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  assign bus = drv_en ? drv : 8'bzzzz_zzzz;

  bus_register #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .enable (enable),
    .load   (load),
`ifdef REGISTER_CLEAR_EN
    .clear  (clear),
`endif
    .value  (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Load a value through the bus in one clock, then release the bus.
  task automatic do_load(input logic [7:0] d);
    @(negedge clk);
    drv_en = 1'b1; drv = d; load = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    load = 1'b0; drv_en = 1'b0;
  endtask

  logic [7:0] pats[4];

  initial begin
    rst_n = 1'b0; enable = 1'b1; load = 1'b0; drv_en = 1'b0; drv = 8'h00;
`ifdef REGISTER_CLEAR_EN
    clear = 1'b0;
`endif
    pats[0] = 8'h80; pats[1] = 8'h01; pats[2] = 8'hFF; pats[3] = 8'h00;

    // Reset with enable high: register drives zero.
    #2;
    sb.push_back(8'h00); chk("rst_bus", bus);
    sb.push_back(8'h00); chk("rst_value", value);
    // Enable low: DUT must not fight a bench driver.
    enable = 1'b0; drv_en = 1'b1; drv = 8'hC3; #1;
    sb.push_back(8'hC3); chk("rst_bus_released", bus);
    // Loads ignored while reset held.
    load = 1'b1; @(posedge clk); #1;
    sb.push_back(8'h00); chk("rst_load_ignored", value);
    load = 1'b0; drv_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Load and readback.
    do_load(8'h55);
    enable = 1'b1; #1;
    sb.push_back(8'h55); chk("readback_bus", bus);
    sb.push_back(8'h55); chk("readback_value", value);
    enable = 1'b0; drv_en = 1'b1; drv = 8'hC3; #1;
    sb.push_back(8'hC3); chk("readback_bus_released", bus);

    // Hold for three cycles with a different value on the bus.
    drv = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sb.push_back(8'h55); chk("hold", value);
    end
    drv_en = 1'b0;

    // Simultaneous load and enable: load suppressed.
    @(negedge clk);
    enable = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    sb.push_back(8'h55); chk("prio_value", value);
    sb.push_back(8'h55); chk("prio_bus", bus);
    @(negedge clk); load = 1'b0; enable = 1'b0;

    // Several distinct patterns.
    for (int i = 0; i < 4; i++) begin
      do_load(pats[i]);
      enable = 1'b1; #1;
      sb.push_back(pats[i]); chk("pattern_bus", bus);
      sb.push_back(pats[i]); chk("pattern_value", value);
      enable = 1'b0;
    end

    // Asynchronous reset between edges.
    do_load(8'hAA);
    sb.push_back(8'hAA); chk("pre_async_value", value);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    sb.push_back(8'h00); chk("async_rst_value", value);
    drv_en = 1'b1; drv = 8'hFF; load = 1'b1;
    @(posedge clk); #1;
    sb.push_back(8'h00); chk("async_rst_load_ignored", value);
    // First edge after release loads.
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(8'hFF); chk("first_load_after_rst", value);
    load = 1'b0; drv_en = 1'b0;

`ifdef REGISTER_CLEAR_EN
    do_load(8'h3C);
    sb.push_back(8'h3C); chk("pre_clear_value", value);
    @(negedge clk);
    clear = 1'b1; load = 1'b1; drv_en = 1'b1; drv = 8'hFF;
    @(posedge clk); #1;
    sb.push_back(8'h00); chk("clear_over_load", value);
    clear = 1'b0; load = 1'b0; drv_en = 1'b0;
    do_load(8'h5A);
    @(negedge clk);
    clear = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    sb.push_back(8'h00); chk("clear_while_enabled", value);
    clear = 1'b0; enable = 1'b0;
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
